// File: rtl/key_event_queue.sv
// Keyboard event FIFO with same-key repeat suppression and a two-consumer
// round-robin delivery port (one event per two cycles).
module key_event_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HOLDOFF = 5000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     key_pressed,
  input  logic [7:0]               keycode,
  input  logic [1:0]               req,
  input  logic                     clr_overflow,
  output logic [1:0]               grant,
  output logic                     out_valid,
  output logic [7:0]               out_keycode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 23;

  localparam logic [TW-1:0] HoldReload = TW'(HOLDOFF - 1);
  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StDeliver} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      last_code_q;
  logic            last_valid_q;
  logic [TW-1:0]   hold_q;
  logic [TW-1:0]   hold_d;
  logic            overflow_q;
  logic            prio_q;
  logic [1:0]      grant_q;
  logic            out_valid_q;
  logic [7:0]      out_keycode_q;

  logic            is_empty;
  logic            is_full;
  logic            pop;
  logic            repeat_hit;
  logic            push;
  logic            drop_full;
  logic            sel;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthCount);

  // Pops only happen from IDLE, which caps throughput at one event per two cycles.
  assign pop = (state_q == StIdle) && !is_empty && (req != 2'b00);

  assign repeat_hit = key_pressed && last_valid_q && (keycode == last_code_q) &&
                      (hold_q != '0);

  // A full FIFO still accepts when the same cycle frees a slot.
  assign push      = key_pressed && !repeat_hit && (!is_full || pop);
  assign drop_full = key_pressed && !repeat_hit && is_full && !pop;

  // sel: index of the consumer served by this pop; prio_q is the favoured one.
  always_comb begin
    sel = 1'b0;
    if (req == 2'b11) begin
      sel = prio_q;
    end else begin
      sel = req[1];
    end
  end

  // A full-FIFO drop leaves the window untouched; otherwise it counts down to 0.
  always_comb begin
    hold_d = hold_q;
    if (repeat_hit || push) begin
      hold_d = HoldReload;
    end else if (drop_full) begin
      hold_d = hold_q;
    end else if (hold_q != '0) begin
      hold_d = hold_q - TW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= keycode;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + AW'(1);
        last_code_q  <= keycode;
        last_valid_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      hold_q <= hold_d;
      if (drop_full) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      out_valid_q   <= 1'b0;
      out_keycode_q <= '0;
      prio_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q       <= StDeliver;
            out_valid_q   <= 1'b1;
            grant_q       <= sel ? 2'b10 : 2'b01;
            out_keycode_q <= mem_q[rd_ptr_q];
            prio_q        <= ~sel;
          end
        end
        StDeliver: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          grant_q     <= 2'b00;
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          grant_q     <= 2'b00;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign out_valid   = out_valid_q;
  assign out_keycode = out_keycode_q;
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign overflow    = overflow_q;

  a_grant_onehot: assert property (@(posedge CLOCK_50) disable iff (reset)
    out_valid |-> $onehot(grant));
  a_grant_idle: assert property (@(posedge CLOCK_50) disable iff (reset)
    !out_valid |-> (grant == 2'b00));
  a_count_bound: assert property (@(posedge CLOCK_50) disable iff (reset)
    count_q <= DepthCount);

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_key_event_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned HOLDOFF = 10;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       key_pressed = 1'b0;
  logic [7:0] keycode = '0;
  logic [1:0] req = 2'b00;
  logic       clr_overflow = 1'b0;
  logic [1:0] grant;
  logic       out_valid;
  logic [7:0] out_keycode;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_last = '0;
  bit         m_last_valid = 0;
  int         m_win = 0;
  bit         m_ovf = 0;
  bit         m_deliv = 0;
  bit         m_ov = 0;
  logic [1:0] m_gnt = '0;
  logic [7:0] m_code = '0;
  int         m_prio = 0;

  key_event_queue #(
    .DEPTH  (DEPTH),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_pressed (key_pressed),
    .keycode     (keycode),
    .req         (req),
    .clr_overflow(clr_overflow),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_keycode (out_keycode),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit do_pop;
    bit same;
    bit accept;
    bit full_drop;
    int c;
    if (reset) begin
      q.delete();
      m_last = '0; m_last_valid = 0; m_win = 0; m_ovf = 0;
      m_deliv = 0; m_ov = 0; m_gnt = '0; m_code = '0; m_prio = 0;
      return;
    end
    do_pop    = !m_deliv && (q.size() > 0) && (req != 2'b00);
    same      = key_pressed && m_last_valid && (keycode == m_last) && (m_win > 0);
    accept    = key_pressed && !same && ((q.size() < DEPTH) || do_pop);
    full_drop = key_pressed && !same && !accept;
    if (m_deliv) begin
      m_deliv = 0; m_ov = 0; m_gnt = 2'b00;
    end else if (do_pop) begin
      if (req == 2'b11) c = m_prio;
      else c = req[1] ? 1 : 0;
      m_code  = q.pop_front();
      m_deliv = 1;
      m_ov    = 1;
      m_gnt   = (c == 1) ? 2'b10 : 2'b01;
      m_prio  = 1 - c;
    end
    if (accept) begin
      q.push_back(keycode);
      m_last = keycode; m_last_valid = 1; m_win = HOLDOFF - 1;
    end else if (same) begin
      m_win = HOLDOFF - 1;
    end else if (!full_drop && m_win > 0) begin
      m_win--;
    end
    if (full_drop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_update();
    #1;
    check_eq("m_valid", 32'(out_valid), 32'(m_ov));
    check_eq("m_grant", 32'(grant), 32'(m_gnt));
    check_eq("m_code", 32'(out_keycode), 32'(m_code));
    check_eq("m_count", 32'(count), 32'(q.size()));
    check_eq("m_empty", 32'(empty), 32'(q.size() == 0));
    check_eq("m_full", 32'(full), 32'(q.size() == DEPTH));
    check_eq("m_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle_inputs();
    key_pressed = 1'b0; keycode = '0; req = 2'b00; clr_overflow = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] code);
    key_pressed = 1'b1; keycode = code;
    step();
    key_pressed = 1'b0;
  endtask

  initial begin
    int got;
    // Reset state
    do_reset();
    step();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_code", 32'(out_keycode), 0);

    // Single push delivered two cycles later to consumer 0
    req = 2'b01;
    push(8'd5);
    check_eq("p1_count", 32'(count), 1);
    check_eq("p1_valid_n1", 32'(out_valid), 0);
    step();
    check_eq("p1_valid", 32'(out_valid), 1);
    check_eq("p1_code", 32'(out_keycode), 5);
    check_eq("p1_grant", 32'(grant), 1);
    step();
    check_eq("p1_empty", 32'(empty), 1);
    check_eq("p1_valid_off", 32'(out_valid), 0);
    check_eq("p1_hold_code", 32'(out_keycode), 5);

    // Fill, overflow, then drain with alternating grants
    do_reset();
    for (int i = 1; i <= 9; i++) push(8'(i));
    check_eq("fill_full", 32'(full), 1);
    check_eq("fill_ovf", 32'(overflow), 1);
    check_eq("fill_count", 32'(count), 8);
    req = 2'b11;
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      step();
      if (out_valid) begin
        check_eq("drain_code", 32'(out_keycode), 32'(got + 1));
        check_eq("drain_grant", 32'(grant), (got % 2 == 0) ? 1 : 2);
        got++;
      end
    end
    check_eq("drain_n", 32'(got), 8);
    req = 2'b00;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_eq("clr_ovf", 32'(overflow), 0);

    // Repeat window: pushes of 7 at offsets 0, 5, 14, 30
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      key_pressed = (c == 0 || c == 5 || c == 14 || c == 30);
      keycode = 8'd7;
      step();
      if (c == 0) check_eq("hold_c0", 32'(count), 1);
      if (c == 5) check_eq("hold_c5", 32'(count), 1);
      if (c == 14) check_eq("hold_c14", 32'(count), 1);
      if (c == 30) check_eq("hold_c30", 32'(count), 2);
    end
    key_pressed = 1'b0;

    // Different code breaks the filter
    do_reset();
    push(8'd7);
    push(8'd8);
    push(8'd7);
    check_eq("diff_count", 32'(count), 3);

    // Full plus pop plus push in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(10 + i));
    req = 2'b01;
    push(8'd20);
    check_eq("fpp_count", 32'(count), 8);
    check_eq("fpp_ovf", 32'(overflow), 0);
    check_eq("fpp_valid", 32'(out_valid), 1);
    req = 2'b00;
    step();

    // Reset during DELIVER
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(30 + i));
    req = 2'b01;
    step();
    check_eq("rd_valid", 32'(out_valid), 1);
    check_eq("rd_count", 32'(count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 2'b00;
    check_eq("rd_count0", 32'(count), 0);
    check_eq("rd_valid0", 32'(out_valid), 0);
    check_eq("rd_ovf0", 32'(overflow), 0);
    push(8'd33);
    check_eq("rd_repush", 32'(count), 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase        = (i / 200) % 3;
      reset        = ($urandom_range(0, 299) == 0);
      key_pressed  = ($urandom_range(0, 9) < 4);
      keycode      = 8'($urandom_range(0, 3));
      clr_overflow = ($urandom_range(0, 19) == 0);
      if (phase == 0) req = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else if (phase == 1) req = 2'($urandom_range(0, 3));
      else req = 2'b11;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
